// File: rtl/key_debounce.sv
// Per-key push-button debouncer with tick-based timing, press/release pulses and auto-repeat.
// All timing is counted in enable_in ticks, so a faster tick source speeds everything up uniformly.
module key_debounce #(
    parameter int unsigned NUM_KEYS     = 4,
    parameter int unsigned STABLE_CNT   = 3,
    parameter int unsigned REPEAT_DELAY = 8,
    parameter int unsigned REPEAT_RATE  = 2,
    parameter int unsigned REPEAT_EN    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_in,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] keys_stable,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_held
);

    localparam int unsigned DW   = $clog2(STABLE_CNT + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } state_t;

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync;

    // Two-flop synchronizer, runs every clock regardless of ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= keys_raw;
            sync      <= sync_meta;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        logic [DW-1:0] deb_cnt;
        logic [DW-1:0] deb_cnt_next;
        logic          stable_q;
        logic          stable_next;
        logic          rise;
        logic          fall;
        state_t        state;
        state_t        state_next;
        logic [RW-1:0] rep_cnt;
        logic [RW-1:0] rep_cnt_next;
        logic          press_next;
        logic          release_next;
        logic          held_next;
        logic          press_q;
        logic          release_q;
        logic          held_q;

        // Count consecutive differing samples; any agreeing sample restarts the count
        always_comb begin
            deb_cnt_next = deb_cnt;
            stable_next  = stable_q;
            rise         = 1'b0;
            fall         = 1'b0;
            if (enable_in) begin
                if (sync[k] != stable_q) begin
                    if (deb_cnt == DW'(STABLE_CNT - 1)) begin
                        deb_cnt_next = '0;
                        stable_next  = sync[k];
                        rise         = sync[k];
                        fall         = ~sync[k];
                    end else begin
                        deb_cnt_next = deb_cnt + DW'(1);
                    end
                end else begin
                    deb_cnt_next = '0;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                deb_cnt  <= '0;
                stable_q <= 1'b0;
            end else begin
                deb_cnt  <= deb_cnt_next;
                stable_q <= stable_next;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state   <= ST_IDLE;
                rep_cnt <= '0;
            end else begin
                state   <= state_next;
                rep_cnt <= rep_cnt_next;
            end
        end

        // Next state: an accepted release always wins over a due repeat
        always_comb begin
            state_next   = state;
            rep_cnt_next = rep_cnt;
            if (enable_in) begin
                if (fall) begin
                    state_next   = ST_IDLE;
                    rep_cnt_next = '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (rise) begin
                                state_next   = ST_PRESSED;
                                rep_cnt_next = '0;
                            end
                        end
                        ST_PRESSED: begin
                            if (REPEAT_EN != 0) begin
                                if (rep_cnt == RW'(REPEAT_DELAY - 1)) begin
                                    state_next   = ST_REPEAT;
                                    rep_cnt_next = '0;
                                end else begin
                                    rep_cnt_next = rep_cnt + RW'(1);
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (rep_cnt == RW'(REPEAT_RATE - 1)) begin
                                rep_cnt_next = '0;
                            end else begin
                                rep_cnt_next = rep_cnt + RW'(1);
                            end
                        end
                        default: begin
                            state_next   = ST_IDLE;
                            rep_cnt_next = '0;
                        end
                    endcase
                end
            end
        end

        always_comb begin
            press_next   = 1'b0;
            release_next = 1'b0;
            held_next    = (state_next == ST_REPEAT);
            if (enable_in) begin
                if (fall) begin
                    release_next = 1'b1;
                end else begin
                    case (state)
                        ST_IDLE:    press_next = rise;
                        ST_PRESSED: press_next = (REPEAT_EN != 0) &&
                                                 (rep_cnt == RW'(REPEAT_DELAY - 1));
                        ST_REPEAT:  press_next = (rep_cnt == RW'(REPEAT_RATE - 1));
                        default:    press_next = 1'b0;
                    endcase
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                held_q    <= 1'b0;
            end else begin
                press_q   <= press_next;
                release_q <= release_next;
                held_q    <= held_next;
            end
        end

        assign keys_stable[k] = stable_q;
        assign key_press[k]   = press_q;
        assign key_release[k] = release_q;
        assign key_held[k]    = held_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table, directed timing sequences and random stimulus vs a tick-level model.
module tb_key_debounce;

    localparam int unsigned NK = 4;
    localparam int unsigned SC = 3;
    localparam int unsigned RD = 8;
    localparam int unsigned RR = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable_in;
    logic [NK-1:0] keys_raw;
    logic [NK-1:0] st0, pr0, rl0, hd0;
    logic [NK-1:0] st1, pr1, rl1, hd1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_debounce #(.NUM_KEYS(NK), .STABLE_CNT(SC), .REPEAT_DELAY(RD),
                   .REPEAT_RATE(RR), .REPEAT_EN(1)) dut_rep (
        .clk(clk), .reset(reset), .enable_in(enable_in), .keys_raw(keys_raw),
        .keys_stable(st0), .key_press(pr0), .key_release(rl0), .key_held(hd0));

    key_debounce #(.NUM_KEYS(NK), .STABLE_CNT(SC), .REPEAT_DELAY(RD),
                   .REPEAT_RATE(RR), .REPEAT_EN(0)) dut_norep (
        .clk(clk), .reset(reset), .enable_in(enable_in), .keys_raw(keys_raw),
        .keys_stable(st1), .key_press(pr1), .key_release(rl1), .key_held(hd1));

    // Reference model: delayed raw history, run length of differing samples, ticks since press
    logic [NK-1:0] m_s1, m_s2, m_stable;
    int            m_run [NK];
    int            m_t   [NK];
    logic [NK-1:0] e_press [2];
    logic [NK-1:0] e_rel;
    logic [NK-1:0] e_held  [2];

    function automatic bit rep_due(input int t, input bit ren);
        if (!ren || t < int'(RD)) return 1'b0;
        return ((t - int'(RD)) % int'(RR)) == 0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; e_rel = '0;
        for (int i = 0; i < 2; i++) begin
            e_press[i] = '0;
            e_held[i]  = '0;
        end
        for (int k = 0; k < int'(NK); k++) begin
            m_run[k] = 0;
            m_t[k]   = 0;
        end
    endtask

    task automatic model_edge();
        bit acc;
        if (reset) begin
            model_reset();
            return;
        end
        e_press[0] = '0; e_press[1] = '0; e_rel = '0;
        if (enable_in) begin
            for (int k = 0; k < int'(NK); k++) begin
                acc = 1'b0;
                if (m_s2[k] != m_stable[k]) begin
                    m_run[k]++;
                    if (m_run[k] == int'(SC)) acc = 1'b1;
                end else begin
                    m_run[k] = 0;
                end
                if (acc) begin
                    m_run[k]    = 0;
                    m_stable[k] = m_s2[k];
                    m_t[k]      = 0;
                    if (m_s2[k]) begin
                        e_press[0][k] = 1'b1;
                        e_press[1][k] = 1'b1;
                    end else begin
                        e_rel[k] = 1'b1;
                    end
                end else if (m_stable[k]) begin
                    m_t[k]++;
                    e_press[0][k] = rep_due(m_t[k], 1'b1);
                    e_press[1][k] = rep_due(m_t[k], 1'b0);
                end
            end
        end
        for (int k = 0; k < int'(NK); k++) begin
            e_held[0][k] = m_stable[k] && (m_t[k] >= int'(RD));
            e_held[1][k] = 1'b0;
        end
        m_s2 = m_s1;
        m_s1 = keys_raw;
    endtask

    task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("model_stable0",  st0, m_stable);
        chk("model_press0",   pr0, e_press[0]);
        chk("model_release0", rl0, e_rel);
        chk("model_held0",    hd0, e_held[0]);
        chk("model_stable1",  st1, m_stable);
        chk("model_press1",   pr1, e_press[1]);
        chk("model_release1", rl1, e_rel);
        chk("model_held1",    hd1, e_held[1]);
    endtask

    task automatic step(input logic en, input logic [NK-1:0] raw);
        enable_in = en;
        keys_raw  = raw;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Press/release a key with ticks spaced 'gap' clocks apart; acceptance must land on tick 3
    task automatic tick_seq(input int gap, input logic [NK-1:0] raw, input bit is_press);
        logic [NK-1:0] seen;
        logic [NK-1:0] st_before;
        logic [NK-1:0] exp_p, exp_r, exp_s;
        st_before = st0;
        seen = '0;
        for (int c = 0; c < 100; c++) begin
            step(1'b0, raw);
            seen |= pr0 | rl0;
        end
        chk("notick_pulses", seen, '0);
        chk("notick_stable", st0, st_before);
        for (int n = 1; n <= 4; n++) begin
            seen = '0;
            for (int g = 1; g < gap; g++) begin
                step(1'b0, raw);
                seen |= pr0 | rl0;
            end
            chk("gap_pulses", seen, '0);
            step(1'b1, raw);
            exp_p = (is_press && n == 3) ? 4'b0100 : 4'b0000;
            exp_r = (!is_press && n == 3) ? 4'b0100 : 4'b0000;
            exp_s = ((n >= 3) == is_press) ? 4'b0100 : 4'b0000;
            chk("tick_press", pr0, exp_p);
            chk("tick_release", rl0, exp_r);
            chk("tick_stable", st0, exp_s);
        end
    endtask

    typedef struct {
        logic          en;
        logic [NK-1:0] raw;
        logic [NK-1:0] exp_stable;
        logic [NK-1:0] exp_press;
        logic [NK-1:0] exp_release;
    } vec_t;

    initial begin
        vec_t          tbl [15];
        int            t;
        int            cnt, c_both, c_other, c_held;
        logic [NK-1:0] exp_p0;
        logic [NK-1:0] r;

        // Bounce table for key0: raw seen by the sampler two clocks later
        tbl[0]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        tbl[10] = '{1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[11] = '{1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[12] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[13] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[14] = '{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};

        reset = 1'b1;
        enable_in = 1'b0;
        keys_raw = '0;
        model_reset();

        // Reset holds every output low even with keys pressed and ticks running
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b1111);
            chk("rst_stable", st0 | st1, '0);
            chk("rst_press", pr0 | pr1, '0);
            chk("rst_release", rl0 | rl1, '0);
            chk("rst_held", hd0 | hd1, '0);
        end
        reset = 1'b0;

        // Acceptance after 2 sync clocks + 3 ticks, then repeat at 8 and every 2 ticks
        cnt = 0;
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, 4'b1111);
            t = i - 5;
            if (t >= int'(RD)) exp_p0 = ((t % int'(RR)) == 0) ? 4'b1111 : 4'b0000;
            else               exp_p0 = (t == 0) ? 4'b1111 : 4'b0000;
            chk("hold_press0", pr0, exp_p0);
            chk("hold_press1", pr1, (t == 0) ? 4'b1111 : 4'b0000);
            chk("hold_stable", st0, (t >= 0) ? 4'b1111 : 4'b0000);
            chk("hold_held0", hd0, (t >= int'(RD)) ? 4'b1111 : 4'b0000);
            chk("hold_held1", hd1, 4'b0000);
            if (i <= 23 && pr0[1]) cnt++;
        end
        chk_int("repeat_count_key1", cnt, 7);

        // Release accepted on a repeat-due tick: release only, no press
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 4'b0000);
            t = 20 + j;
            chk("relprio_press0", pr0, (t < 24 && (t % 2) == 0) ? 4'b1111 : 4'b0000);
            chk("relprio_release0", rl0, (t == 24) ? 4'b1111 : 4'b0000);
            chk("relprio_release1", rl1, (t == 24) ? 4'b1111 : 4'b0000);
            chk("relprio_held0", hd0, (t < 24) ? 4'b1111 : 4'b0000);
            chk("relprio_stable", st0, (t < 24) ? 4'b1111 : 4'b0000);
            chk("relprio_press1", pr1, 4'b0000);
        end

        // Tick dependence: same tick count regardless of tick spacing
        tick_seq(1, 4'b0100, 1'b1);
        tick_seq(5, 4'b0000, 1'b0);
        tick_seq(5, 4'b0100, 1'b1);
        tick_seq(1, 4'b0000, 1'b0);

        // No-repeat instance: simultaneous press and release of keys 0 and 3
        c_both = 0; c_other = 0; c_held = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 4'b1001);
            if (pr1 == 4'b1001) c_both++;
            else if (pr1 != 4'b0000) c_other++;
            if (hd1 != 4'b0000) c_held++;
        end
        chk_int("norep_press_both", c_both, 1);
        chk_int("norep_press_other", c_other, 0);
        chk_int("norep_held", c_held, 0);
        c_both = 0; c_other = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b0000);
            if (rl1 == 4'b1001) c_both++;
            else if (rl1 != 4'b0000) c_other++;
        end
        chk_int("norep_release_both", c_both, 1);
        chk_int("norep_release_other", c_other, 0);

        // Vector table from a clean reset
        reset = 1'b1;
        model_reset();
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0000);
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].en, tbl[i].raw);
            chk("tbl_stable", st0, tbl[i].exp_stable);
            chk("tbl_press", pr0, tbl[i].exp_press);
            chk("tbl_release", rl0, tbl[i].exp_release);
        end

        // Random stimulus with occasional mid-run resets against the model
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 1000) == 500) begin
                reset = 1'b1;
                model_reset();
                #1;
                chk_model();
                step(($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, r);
                chk_model();
                reset = 1'b0;
            end
            for (int k = 0; k < int'(NK); k++)
                if ($urandom_range(0, 7) == 0) r[k] = ~r[k];
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, r);
            chk_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
